// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 20 ms debounce and 1 s long-press at a 50 MHz clock.
    localparam int DEBOUNCE_CYCLES_DEF   = 1_000_000;
    localparam int LONG_PRESS_CYCLES_DEF = 50_000_000;

    // Width of a counter that must hold values 0 .. n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a configurable reset level.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep meta and q as two distinct flop stages;
    // blocking ones would collapse the chain into a single register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: debounced level plus one-cycle press/release strobes.
// Define BTN_LONG_PRESS_EN to build the long-press counter; otherwise LONG_PRESS is tied to 0.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF,
    parameter bit BTN_ACTIVE_LOW    = 1'b1
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN_IN,
    output logic BTN_STATE,
    output logic BTN_PRESS,
    output logic BTN_RELEASE,
    output logic LONG_PRESS
);

    localparam int               DB_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES < 1) begin : g_bad_params
            $error("button_debouncer: DEBOUNCE_CYCLES and LONG_PRESS_CYCLES must be >= 1");
        end
    endgenerate

    logic            btn_sync;
    logic            pressed;
    btn_state_t      state;
    logic [DB_W-1:0] cnt;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (BTN_ACTIVE_LOW)
    ) u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (BTN_IN),
        .q     (btn_sync)
    );

    assign pressed = btn_sync ^ BTN_ACTIVE_LOW;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= IDLE;
            cnt         <= '0;
            BTN_STATE   <= 1'b0;
            BTN_PRESS   <= 1'b0;
            BTN_RELEASE <= 1'b0;
        end else begin
            BTN_PRESS   <= 1'b0;
            BTN_RELEASE <= 1'b0;
            case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        BTN_STATE <= 1'b1;
                        BTN_PRESS <= 1'b1;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed resumes the hold without a new press event.
                    if (pressed) begin
                        state <= HELD;
                    end else if (cnt == DB_LAST) begin
                        state       <= IDLE;
                        BTN_STATE   <= 1'b0;
                        BTN_RELEASE <= 1'b1;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam int                LONG_W    = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_PRESS_CYCLES - 1);

    logic              press_accept;
    logic [LONG_W-1:0] long_cnt;
    logic              long_done;

    assign press_accept = (state == PRESS_WAIT) && pressed && (cnt == DB_LAST);

    // Counts only cycles spent in HELD; frozen in RELEASE_WAIT and saturated once fired.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            long_cnt   <= '0;
            long_done  <= 1'b0;
            LONG_PRESS <= 1'b0;
        end else begin
            LONG_PRESS <= 1'b0;
            if (press_accept) begin
                long_cnt  <= '0;
                long_done <= 1'b0;
            end else if (state == HELD && !long_done) begin
                if (long_cnt == LONG_LAST) begin
                    LONG_PRESS <= 1'b1;
                    long_done  <= 1'b1;
                end else begin
                    long_cnt <= long_cnt + LONG_W'(1);
                end
            end
        end
    end
`else
    assign LONG_PRESS = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with an event scoreboard (DEBOUNCE=4, LONG_PRESS=10, active-low pin).
module tb_button_debouncer;

    localparam int DB = 4;
    localparam int LP = 10;

    typedef enum int {EV_NONE, EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic btn_state;
    logic btn_press;
    logic btn_release;
    logic long_press;

    int  cyc      = 0;
    int  checks   = 0;
    int  failures = 0;
    ev_t exp_q[$];

    button_debouncer #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .BTN_ACTIVE_LOW    (1'b1)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .BTN_IN      (btn_in),
        .BTN_STATE   (btn_state),
        .BTN_PRESS   (btn_press),
        .BTN_RELEASE (btn_release),
        .LONG_PRESS  (long_press)
    );

    always #5 clk = ~clk;

    // cyc == N between rising edge N and rising edge N+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic observe(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_event", 32'(k), 32'(EV_NONE));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    always @(negedge clk) begin
        if (btn_press)   observe(EV_PRESS);
        if (btn_release) observe(EV_RELEASE);
        if (long_press)  observe(EV_LONG);
    end

    task automatic expect_event(input ev_kind_t k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    // Advance to the falling edge that follows rising edge e.
    task automatic at_edge(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic check_outputs_clear(input string tag);
        check({tag, "_state"},   32'(btn_state),   32'(0));
        check({tag, "_press"},   32'(btn_press),   32'(0));
        check({tag, "_release"}, 32'(btn_release), 32'(0));
        check({tag, "_long"},    32'(long_press),  32'(0));
    endtask

    initial begin
        // Reset with the button pressed: nothing may come out.
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_outputs_clear("reset");
        end
        rst_n  = 1'b1;
        btn_in = 1'b1;

        // Clean press sampled at edge 10, release sampled at edge 30.
        at_edge(9);
        check("idle_after_reset", 32'(btn_state), 32'(0));
        btn_in = 1'b0;
        expect_event(EV_PRESS, 10 + 2 + DB);
`ifdef BTN_LONG_PRESS_EN
        expect_event(EV_LONG, 10 + 2 + DB + LP);
`endif
        at_edge(15);
        check("state_before_press", 32'(btn_state), 32'(0));
        at_edge(16);
        check("state_at_press", 32'(btn_state), 32'(1));
        at_edge(29);
        check("state_holding", 32'(btn_state), 32'(1));
        btn_in = 1'b1;
        expect_event(EV_RELEASE, 30 + 2 + DB);
        at_edge(35);
        check("state_before_release", 32'(btn_state), 32'(1));
        at_edge(36);
        check("state_at_release", 32'(btn_state), 32'(0));

        // Bounce: 3 low / 2 high, five times, starting at edge 40.
        at_edge(39);
        for (int r = 0; r < 5; r++) begin
            btn_in = 1'b0;
            repeat (3) begin
                @(negedge clk);
                check("bounce_state", 32'(btn_state), 32'(0));
            end
            btn_in = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check("bounce_state", 32'(btn_state), 32'(0));
            end
        end

        // Glitch boundary: a 4-cycle pulse is rejected, a 5-cycle pulse is accepted.
        at_edge(69);
        btn_in = 1'b0;
        at_edge(73);
        btn_in = 1'b1;
        at_edge(80);
        check("pulse4_rejected", 32'(btn_state), 32'(0));
        at_edge(84);
        btn_in = 1'b0;
        expect_event(EV_PRESS, 85 + 2 + DB);
        at_edge(89);
        btn_in = 1'b1;
        expect_event(EV_RELEASE, 90 + 2 + DB);
        at_edge(91);
        check("pulse5_state", 32'(btn_state), 32'(1));
        at_edge(96);
        check("pulse5_released", 32'(btn_state), 32'(0));

        // Release bounce while HELD: 2 high cycles then low again.
        at_edge(99);
        btn_in = 1'b0;
        expect_event(EV_PRESS, 100 + 2 + DB);
        at_edge(105);
        check("rb_before_press", 32'(btn_state), 32'(0));
        at_edge(106);
        check("rb_at_press", 32'(btn_state), 32'(1));
        at_edge(109);
        btn_in = 1'b1;
        at_edge(111);
        btn_in = 1'b0;
        at_edge(113);
        btn_in = 1'b1;
        expect_event(EV_RELEASE, 114 + 2 + DB);
        for (int e = 112; e < 120; e++) begin
            at_edge(e);
            check("rb_state_held", 32'(btn_state), 32'(1));
        end
        at_edge(120);
        check("rb_released", 32'(btn_state), 32'(0));

        // Long press: held for 40 cycles.
        at_edge(129);
        btn_in = 1'b0;
        expect_event(EV_PRESS, 130 + 2 + DB);
`ifdef BTN_LONG_PRESS_EN
        expect_event(EV_LONG, 130 + 2 + DB + LP);
`endif
        at_edge(169);
        check("long_holding", 32'(btn_state), 32'(1));
        btn_in = 1'b1;
        expect_event(EV_RELEASE, 170 + 2 + DB);
        at_edge(176);
        check("long_released", 32'(btn_state), 32'(0));

        // Reset mid-hold, on the edge where LONG_PRESS would otherwise fire.
        at_edge(189);
        btn_in = 1'b0;
        expect_event(EV_PRESS, 190 + 2 + DB);
        at_edge(205);
        check("pre_reset_state", 32'(btn_state), 32'(1));
        rst_n = 1'b0;
        at_edge(206);
        check_outputs_clear("mid_reset");
        rst_n = 1'b1;
        expect_event(EV_PRESS, 206 + 1 + 2 + DB);
        at_edge(212);
        check("after_reset_waiting", 32'(btn_state), 32'(0));
        at_edge(213);
        check("after_reset_pressed", 32'(btn_state), 32'(1));
        at_edge(216);
        btn_in = 1'b1;
        expect_event(EV_RELEASE, 217 + 2 + DB);
        at_edge(223);
        check("after_reset_released", 32'(btn_state), 32'(0));

        at_edge(240);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions a raw mechanical push-button into clean, single-clock control events for the LED blink logic. It sits directly upstream of the blink counter and provides a debounced level plus one-cycle press and release strobes, which the blink stage uses for enable and mode toggling. The raw input is asynchronous and is synchronised internally.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: number of consecutive stable synchronised samples required to accept a change; 20 ms at 50 MHz; must be ≥ 1.
- `LONG_PRESS_CYCLES`, default 50_000_000: hold time after an accepted press before `LONG_PRESS` fires; 1 s at 50 MHz; must be ≥ 1.
- `BTN_ACTIVE_LOW`, default 1: 1 means a pressed button drives `BTN_IN` low.
- `CLK` input, 1 bit: the single clock; every flop is on its rising edge.
- `RST_N` input, 1 bit: reset, synchronous and active-low.
- `BTN_IN` input, 1 bit: raw, asynchronous button pin.
- `BTN_STATE` output, 1 bit: debounced level; 1 means pressed.
- `BTN_PRESS` output, 1 bit: one-cycle strobe when a press is accepted.
- `BTN_RELEASE` output, 1 bit: one-cycle strobe when a release is accepted.
- `LONG_PRESS` output, 1 bit: one-cycle strobe when a press has been held for `LONG_PRESS_CYCLES`.

## Operation
- Input path:
  - `BTN_IN` passes through a 2-flop synchroniser.
  - It is then normalised to `pressed` using `BTN_ACTIVE_LOW`.
- FSM states: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Debounce counter width is `$clog2(DEBOUNCE_CYCLES)`, minimum 1.
- IDLE:
  - `pressed` → PRESS_WAIT, cnt ← 0.
- PRESS_WAIT:
  - `!pressed` → IDLE.
  - Otherwise, if cnt == DEBOUNCE_CYCLES−1 → HELD, `BTN_PRESS` ← 1, long counter ← 0.
  - Otherwise cnt ← cnt+1.
- HELD:
  - `!pressed` → RELEASE_WAIT, cnt ← 0.
- RELEASE_WAIT:
  - `pressed` → HELD. No new `BTN_PRESS`. Long counter resumes from its frozen value.
  - Otherwise, if cnt == DEBOUNCE_CYCLES−1 → IDLE, `BTN_RELEASE` ← 1.
  - Otherwise cnt ← cnt+1.
- `BTN_STATE` is 1 in HELD and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT. It is registered together with the state.
- Strobes are registered and last exactly one cycle. `BTN_PRESS` and `BTN_RELEASE` are never high in the same cycle.
- Glitch rejection: a synchronised pulse shorter than DEBOUNCE_CYCLES+1 cycles produces no event.

## Timing
- Reset value of every output is 0. After reset the state is IDLE, all counters are 0, and the synchroniser flops hold the not-pressed level.
- Press latency: with `BTN_IN` held stable from clock edge E, `BTN_PRESS` and `BTN_STATE` go high after edge E+2+DEBOUNCE_CYCLES.
- Release latency: the same figure, E+2+DEBOUNCE_CYCLES, for `BTN_RELEASE` high and `BTN_STATE` low.
- Long press:
  - `LONG_PRESS` goes high LONG_PRESS_CYCLES cycles after the `BTN_PRESS` cycle, counting only cycles spent in HELD.
  - It fires once per press and the counter saturates.
  - It never fires after `BTN_RELEASE`.
- Reset mid-operation: `RST_N` low for one edge returns the block to IDLE and clears all strobes. A button still held after reset produces a fresh `BTN_PRESS` after the full press latency.
- Simultaneous events: reset dominates every other condition.

## Configuration
- `BTN_LONG_PRESS_EN` defined: the long counter, of width `$clog2(LONG_PRESS_CYCLES)`, and the `LONG_PRESS` logic are built.
- `BTN_LONG_PRESS_EN` undefined: no long counter is synthesised and `LONG_PRESS` is tied to 0. The port list is unchanged.

## Structure
- Package `button_pkg`:
  - `btn_state_t` enum: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
  - Default constants `DEBOUNCE_CYCLES_DEF` and `LONG_PRESS_CYCLES_DEF`.
- Sub-module `sync_2ff`: a generic 2-flop synchroniser with a reset value parameter. It is reused by other asynchronous inputs.
- The FSM and counters live in `button_debouncer`.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, BTN_ACTIVE_LOW=1 and `BTN_LONG_PRESS_EN` defined.
- Reset state: hold `RST_N` low for 3 cycles with `BTN_IN`=0. Required response: all outputs 0, and a pressed `BTN_IN` during reset produces no strobe.
- Clean press and release: drive `BTN_IN` low at edge 10 and high at edge 30.
  - Required response: `BTN_PRESS` high only after edge 16, with `BTN_STATE` 1 from then on.
  - Required response: `BTN_RELEASE` high only after edge 36, with `BTN_STATE` 0 from then on.
- Bounce rejection: drive `BTN_IN` low for 3 cycles, then high for 2, repeated 5 times. Required response: no strobes and `BTN_STATE` stays 0.
- Release bounce: while in HELD, drive `BTN_IN` high for 2 cycles and then low again. Required response: no `BTN_RELEASE`, no second `BTN_PRESS`, and `BTN_STATE` stays 1.
- Long press: hold the button pressed for 40 cycles. Required response: exactly one `LONG_PRESS`, 10 cycles after `BTN_PRESS`, and none on release.
- Reset mid-hold: assert `RST_N` low for 1 cycle while in HELD with the button still pressed. Required response: outputs clear, then a new `BTN_PRESS` 6 cycles after `RST_N` rises.
